// File: rtl/if_stage_pfq.sv
// if_stage_pfq: instruction-fetch stage with a prefetch queue between the
// instruction SRAM (1-cycle read latency) and decode. Fetch keeps streaming
// while decode stalls. Branch redirects flush the queue and drop any
// response that belongs to the old path.
// Optional build macro IF_ADEF_EN adds an address-fault bit (bus bit 64).
// With it, a misaligned fetch address is not sent to the SRAM. It becomes a
// faulting entry instead, and fetch halts until the next redirect.

// Overflow checker for the prefetch queue.
module if_stage_pfq_chk #(
    parameter int QUEUE_DEPTH = 4,
    parameter int CNT_W       = 3
) (
    input logic             clk,
    input logic             reset,
    input logic             push,
    input logic             pop,
    input logic [CNT_W-1:0] count
);
    // A push into a full queue without a matching pop would lose an entry.
    a_no_overflow: assert property (@(posedge clk) disable iff (reset)
        !(push && !pop && (count == CNT_W'(QUEUE_DEPTH))));
endmodule

module if_stage_pfq #(
    parameter logic [31:0] RESET_PC    = 32'h1c000000,
    parameter int          QUEUE_DEPTH = 4,
    localparam int         PTR_W       = $clog2(QUEUE_DEPTH),
`ifdef IF_ADEF_EN
    localparam int         BUS_W       = 65
`else
    localparam int         BUS_W       = 64
`endif
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             ds_allowin,
    input  logic [33:0]      br_bus,
    output logic             inst_sram_en,
    output logic [3:0]       inst_sram_we,
    output logic [31:0]      inst_sram_addr,
    output logic [31:0]      inst_sram_wdata,
    input  logic [31:0]      inst_sram_rdata,
    output logic             fs_to_ds_valid,
    output logic [BUS_W-1:0] fs_to_ds_bus
);
    localparam int CNT_W = PTR_W + 1;
    localparam int OCC_W = CNT_W + 1;

    logic        br_stall_s;
    logic        br_taken_s;
    logic [31:0] br_target_s;
    assign {br_stall_s, br_taken_s, br_target_s} = br_bus;

    logic [31:0]      req_pc_q, req_pc_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
    logic             inflight_q, inflight_d;
    logic             inflight_kill_q, inflight_kill_d;
    logic [31:0]      inflight_pc_q, inflight_pc_d;
    logic [31:0]      pc_mem_q   [QUEUE_DEPTH];
    logic [31:0]      pc_mem_d   [QUEUE_DEPTH];
    logic [31:0]      inst_mem_q [QUEUE_DEPTH];
    logic [31:0]      inst_mem_d [QUEUE_DEPTH];

    logic [OCC_W-1:0] occupancy_s;
    logic [31:0]      fetch_addr_s;
    logic             room_s, issue_s, sram_req_s, push_s, valid_s, pop_s;
    logic [31:0]      push_inst_s;

`ifdef IF_ADEF_EN
    logic             halt_q, halt_d;
    logic             inflight_adef_q, inflight_adef_d;
    logic             adef_mem_q [QUEUE_DEPTH];
    logic             adef_mem_d [QUEUE_DEPTH];
    logic             misalign_s;
`endif

    // Issue, push and pop decisions from registered state and this cycle's inputs.
    always_comb begin
        occupancy_s  = {1'b0, count_q} + {{CNT_W{1'b0}}, inflight_q};
        room_s       = (occupancy_s < OCC_W'(QUEUE_DEPTH));
        fetch_addr_s = br_taken_s ? br_target_s : req_pc_q;
`ifdef IF_ADEF_EN
        misalign_s   = (fetch_addr_s[1:0] != 2'b00);
        issue_s      = !reset && room_s && (br_taken_s || !halt_q);
        sram_req_s   = issue_s && !misalign_s;
        push_inst_s  = inflight_adef_q ? 32'h0 : inst_sram_rdata;
`else
        issue_s      = !reset && room_s;
        sram_req_s   = issue_s;
        push_inst_s  = inst_sram_rdata;
`endif
        // A redirect drops the response arriving in the same cycle.
        push_s  = inflight_q && !inflight_kill_q && !br_taken_s;
        valid_s = (count_q != CNT_W'(0)) && !br_stall_s && !br_taken_s;
        pop_s   = valid_s && ds_allowin;
    end

    // Next-state computation for fetch PC, in-flight tracking and the queue.
    always_comb begin
        pc_mem_d   = pc_mem_q;
        inst_mem_d = inst_mem_q;
        if (issue_s) begin
            req_pc_d = fetch_addr_s + 32'd4;
        end else if (br_taken_s) begin
            req_pc_d = br_target_s;
        end else begin
            req_pc_d = req_pc_q;
        end
        inflight_d      = issue_s;
        inflight_pc_d   = issue_s ? fetch_addr_s : inflight_pc_q;
        // With 1-cycle latency every pre-redirect response lands in the
        // redirect cycle itself and is dropped there, so nothing stays marked.
        inflight_kill_d = 1'b0;
        if (br_taken_s) begin
            count_d  = CNT_W'(0);
            rd_ptr_d = PTR_W'(0);
            wr_ptr_d = PTR_W'(0);
        end else begin
            count_d  = count_q + CNT_W'(push_s) - CNT_W'(pop_s);
            rd_ptr_d = rd_ptr_q + PTR_W'(pop_s);
            wr_ptr_d = wr_ptr_q + PTR_W'(push_s);
        end
        if (push_s) begin
            pc_mem_d[wr_ptr_q]   = inflight_pc_q;
            inst_mem_d[wr_ptr_q] = push_inst_s;
        end else begin
            pc_mem_d[wr_ptr_q]   = pc_mem_q[wr_ptr_q];
            inst_mem_d[wr_ptr_q] = inst_mem_q[wr_ptr_q];
        end
    end

`ifdef IF_ADEF_EN
    // Fault tracking: a misaligned issue becomes a faulting entry and halts fetch.
    always_comb begin
        adef_mem_d      = adef_mem_q;
        inflight_adef_d = issue_s && misalign_s;
        if (issue_s && misalign_s) begin
            halt_d = 1'b1;
        end else if (br_taken_s) begin
            halt_d = 1'b0;
        end else begin
            halt_d = halt_q;
        end
        if (push_s) begin
            adef_mem_d[wr_ptr_q] = inflight_adef_q;
        end else begin
            adef_mem_d[wr_ptr_q] = adef_mem_q[wr_ptr_q];
        end
    end

    // Fault-state registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            halt_q          <= 1'b0;
            inflight_adef_q <= 1'b0;
            for (int i = 0; i < QUEUE_DEPTH; i++) adef_mem_q[i] <= 1'b0;
        end else begin
            halt_q          <= halt_d;
            inflight_adef_q <= inflight_adef_d;
            adef_mem_q      <= adef_mem_d;
        end
    end
`endif

    // Main state registers; asynchronous reset clears everything at once.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            req_pc_q        <= RESET_PC;
            count_q         <= CNT_W'(0);
            rd_ptr_q        <= PTR_W'(0);
            wr_ptr_q        <= PTR_W'(0);
            inflight_q      <= 1'b0;
            inflight_kill_q <= 1'b0;
            inflight_pc_q   <= 32'h0;
            for (int i = 0; i < QUEUE_DEPTH; i++) begin
                pc_mem_q[i]   <= 32'h0;
                inst_mem_q[i] <= 32'h0;
            end
        end else begin
            req_pc_q        <= req_pc_d;
            count_q         <= count_d;
            rd_ptr_q        <= rd_ptr_d;
            wr_ptr_q        <= wr_ptr_d;
            inflight_q      <= inflight_d;
            inflight_kill_q <= inflight_kill_d;
            inflight_pc_q   <= inflight_pc_d;
            pc_mem_q        <= pc_mem_d;
            inst_mem_q      <= inst_mem_d;
        end
    end

    assign inst_sram_en    = sram_req_s;
    assign inst_sram_addr  = fetch_addr_s;
    assign inst_sram_we    = 4'b0;
    assign inst_sram_wdata = 32'b0;
    assign fs_to_ds_valid  = valid_s;
`ifdef IF_ADEF_EN
    assign fs_to_ds_bus = {adef_mem_q[rd_ptr_q], pc_mem_q[rd_ptr_q], inst_mem_q[rd_ptr_q]};
`else
    assign fs_to_ds_bus = {pc_mem_q[rd_ptr_q], inst_mem_q[rd_ptr_q]};
`endif

    if_stage_pfq_chk #(.QUEUE_DEPTH(QUEUE_DEPTH), .CNT_W(CNT_W)) u_chk (
        .clk   (clk),
        .reset (reset),
        .push  (push_s),
        .pop   (pop_s),
        .count (count_q)
    );
endmodule
